// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter driving open-drain enables.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clock,
  input  logic       ps_data,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, BITS, ACK, RELEASE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1, clk_s2, clk_p;
  logic          dat_s1, dat_s2;
  logic          fe;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic          drv_q, drv_d;
  logic          err_q, err_d;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_p  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fe     <= 1'b0;
    end else begin
      clk_s1 <= ps_clock;
      clk_s2 <= clk_s1;
      clk_p  <= clk_s2;
      dat_s1 <= ps_data;
      dat_s2 <= dat_s1;
      fe     <= clk_p & ~clk_s2;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      inh_q   <= '0;
      drv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      inh_q   <= inh_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    inh_d   = inh_q;
    drv_d   = drv_q;
    err_d   = err_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = {1'b1, ~^data, data};
          err_d   = 1'b0;
          bit_d   = '0;
          inh_d   = IW'(INHIBIT_CYCLES - 1);
          drv_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == '0) begin
          drv_d   = 1'b1;
          state_d = REQ;
        end else begin
          inh_d = inh_q - IW'(1);
        end
      end
      REQ: begin
        if (fe) begin
          drv_d   = ~frame_q[0];
          frame_d = {1'b0, frame_q[9:1]};
          state_d = BITS;
        end
      end
      BITS: begin
        if (fe) begin
          if (bit_q == 4'd9) begin
            // ACK slot: device must hold data low here
            err_d   = dat_s2;
            state_d = ACK;
          end else begin
            bit_d   = bit_q + 4'd1;
            drv_d   = ~frame_q[0];
            frame_d = {1'b0, frame_q[9:1]};
          end
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (clk_s2 && dat_s2) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == INHIBIT) begin
      wd_d = '0;
    end else if (state_q inside {REQ, BITS, ACK, RELEASE}) begin
      if (fe) begin
        wd_d = '0;
      end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        wd_d    = '0;
        drv_d   = 1'b0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
`endif
  end

  // Data falls in the last inhibit cycle while clock is still held low.
  assign ps_clk_oe = (state_q == INHIBIT);
  assign ps_dat_oe = drv_q | ((state_q == INHIBIT) && (inh_q == '0));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: PS/2 device model with scoreboard of expected frames/results.
// Covers ACK/NACK, parity, inhibit timing, ignored start, reset, watchdog.
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int INH = 2500;
  localparam int TMO = 3000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps_clock, ps_data;
  logic       ps_clk_oe, ps_dat_oe;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       busy, done, error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  bit   ack_en = 1'b1;
  bit   dev_active = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [10:0] exp_frame_q[$];
  logic        exp_err_q[$];
  logic [10:0] obs_q[$];

  assign ps_clock = ps_clk_oe ? 1'b0 : dev_clk;
  assign ps_data  = ps_dat_oe ? 1'b0 : dev_dat;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps_clock (ps_clock),
    .ps_data  (ps_data),
    .ps_clk_oe(ps_clk_oe),
    .ps_dat_oe(ps_dat_oe),
    .start    (start),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #20 clock = ~clock;

  always @(negedge clock) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Device: samples data at each clock rising edge (first one is the
  // host releasing the inhibit), then clocks the ACK slot.
  initial begin : device
    logic [10:0] obs;
    forever begin
      @(negedge clock);
      if (ps_clk_oe) begin
        for (int k = 0; k < 20000 && ps_clk_oe; k++) @(negedge clock);
        if (dev_active && !ps_clk_oe && !ps_data) begin
          obs = '0;
          obs[0] = ps_data;
          for (int i = 1; i < 11; i++) begin
            repeat (10) @(negedge clock);
            dev_clk = 1'b0;
            repeat (20) @(negedge clock);
            obs[i] = ps_data;
            dev_clk = 1'b1;
          end
          repeat (5) @(negedge clock);
          dev_dat = ack_en ? 1'b0 : 1'b1;
          repeat (5) @(negedge clock);
          dev_clk = 1'b0;
          repeat (20) @(negedge clock);
          dev_clk = 1'b1;
          repeat (5) @(negedge clock);
          dev_dat = 1'b1;
          obs_q.push_back(obs);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit ack,
                      input int mid_at, input bit timing);
    int first_clk, first_dat, clk_hi, dn0;
    bit seen;
    logic [10:0] ef, obs;
    logic ee;
    exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
    exp_err_q.push_back(!ack);
    ack_en = ack;
    dn0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    data  = d;
    @(negedge clock);
    start = 1'b0;
    first_clk = -1;
    first_dat = -1;
    clk_hi = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (ps_clk_oe) begin
        clk_hi++;
        if (first_clk < 0) first_clk = cyc;
      end
      if (ps_dat_oe && first_dat < 0) first_dat = cyc;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (cyc == mid_at);
      if (cyc == mid_at) data = 8'h00;
      @(negedge clock);
    end
    start = 1'b0;
    ef = exp_frame_q.pop_front();
    ee = exp_err_q.pop_front();
    chk("done_seen", 32'(seen), 32'd1);
    chk("error", 32'(error), 32'(ee));
    chk("busy_at_done", 32'(busy), 32'd1);
    @(negedge clock);
    chk("busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clock);
    if (obs_q.size() > 0) obs = obs_q.pop_front();
    else obs = 'x;
    chk("frame", 32'(obs), 32'(ef));
    chk("parity", 32'(obs[9]), 32'(ef[9]));
    if (timing) begin
      chk("inh_start", 32'(first_clk), 32'd0);
      chk("inh_len", 32'(clk_hi), 32'(INH));
      chk("dat_lead", 32'(first_dat - first_clk), 32'(INH - 1));
    end
    repeat (60) @(negedge clock);
    chk("done_count", 32'(done_cnt - dn0), 32'd1);
  endtask

  initial begin : main
    int dn0;
    repeat (3) @(negedge clock);
    chk("rst_clk_oe", 32'(ps_clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(ps_dat_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    send(8'hED, 1'b1, -1, 1'b1);
    send(8'h01, 1'b1, -1, 1'b0);
    send(8'hFF, 1'b1, -1, 1'b0);
    send(8'h5A, 1'b0, -1, 1'b0);
    send(8'hF4, 1'b1, 2700, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    begin : timeout_case
      int req, dcyc;
      bit seen;
      dev_active = 1'b0;
      @(negedge clock);
      start = 1'b1;
      data  = 8'hAA;
      @(negedge clock);
      start = 1'b0;
      req = -1;
      dcyc = -1;
      seen = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        if (!ps_clk_oe && req < 0 && cyc > 0) req = cyc;
        if (done) begin
          seen = 1'b1;
          dcyc = cyc;
          break;
        end
        @(negedge clock);
      end
      chk("to_done", 32'(seen), 32'd1);
      chk("to_error", 32'(error), 32'd1);
      chk("to_clk_oe", 32'(ps_clk_oe), 32'd0);
      chk("to_dat_oe", 32'(ps_dat_oe), 32'd0);
      chk("to_min", 32'(dcyc - req >= TMO), 32'd1);
      chk("to_max", 32'(dcyc - req <= TMO + 2), 32'd1);
      dev_active = 1'b1;
      repeat (20) @(negedge clock);
    end
`endif

    ack_en = 1'b1;
    dn0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    data  = 8'h5A;
    @(negedge clock);
    start = 1'b0;
    repeat (2700) @(negedge clock);
    chk("busy_pre_rst", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_clk_oe", 32'(ps_clk_oe), 32'd0);
    chk("rst_mid_dat_oe", 32'(ps_dat_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (1000) @(negedge clock);
    chk("rst_no_done", 32'(done_cnt - dn0), 32'd0);
    obs_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
